lu_issue_stage: RTL and testbench

Operand issue and result-capture stage wrapped around `logic_unit`. It buffers incoming (a, b, sel) operations in a DEPTH-entry FIFO and drives the head entry onto the combinational `logic_unit` inputs. It registers the returned `res` into a valid/ready output slot. It sits directly upstream of `logic_unit`, and its output register is the stage boundary to the consumer.

---
 rtl/lu_issue_stage.sv | 165 ++++++++++++++++
 tb/tb_lu_issue_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lu_issue_stage.sv
// lu_issue_stage
//   Operand issue and result-capture stage placed in front of the
//   combinational logic_unit. Incoming (a, b, sel) operations are buffered in
//   a DEPTH-entry FIFO. The head entry is driven onto lu_a/lu_b/lu_sel. The
//   returned lu_res is captured into a valid/ready output slot.
//
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid/in_ready     : upstream handshake
//   in_a, in_b, in_sel    : operation accepted when in_valid && in_ready
//   lu_a, lu_b, lu_sel    : head FIFO entry to logic_unit (zero when empty)
//   lu_res                : combinational result from logic_unit
//   out_valid/out_ready   : downstream handshake
//   out_res, out_sel      : captured result and the sel that produced it
//   count                 : FIFO occupancy, 0..DEPTH
//   out_zero              : registered (lu_res == 0) flag, only present when
//                           LU_ISSUE_ZERO_FLAG_EN is defined
//
// Handshake rule: a transfer happens on a rising edge where valid && ready.
// valid does not depend on ready. in_ready is a function of registered
// occupancy only and never looks at out_ready.
module lu_issue_stage #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [2:0]                 in_sel,
  output logic [WIDTH-1:0]           lu_a,
  output logic [WIDTH-1:0]           lu_b,
  output logic [2:0]                 lu_sel,
  input  logic [WIDTH-1:0]           lu_res,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_res,
  output logic [2:0]                 out_sel,
  output logic [$clog2(DEPTH):0]     count
`ifdef LU_ISSUE_ZERO_FLAG_EN
  ,
  output logic                       out_zero
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_a_q   [DEPTH];
  logic [WIDTH-1:0] mem_a_d   [DEPTH];
  logic [WIDTH-1:0] mem_b_q   [DEPTH];
  logic [WIDTH-1:0] mem_b_d   [DEPTH];
  logic [2:0]       mem_sel_q [DEPTH];
  logic [2:0]       mem_sel_d [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_res_q, out_res_d;
  logic [2:0]       out_sel_q, out_sel_d;
`ifdef LU_ISSUE_ZERO_FLAG_EN
  logic             out_zero_q, out_zero_d;
`endif

  logic not_empty;
  logic push;
  logic pop;

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign push      = in_valid && in_ready;
  // The head is registered, so an op pushed into an empty FIFO cannot pop
  // in the same cycle: not_empty is still low.
  assign pop       = not_empty && (!out_valid_q || out_ready);

  assign lu_a   = not_empty ? mem_a_q[rd_ptr_q]   : '0;
  assign lu_b   = not_empty ? mem_b_q[rd_ptr_q]   : '0;
  assign lu_sel = not_empty ? mem_sel_q[rd_ptr_q] : '0;

  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_sel   = out_sel_q;
  assign count     = count_q;
`ifdef LU_ISSUE_ZERO_FLAG_EN
  assign out_zero  = out_zero_q;
`endif

  always_comb begin
    mem_a_d     = mem_a_q;
    mem_b_d     = mem_b_q;
    mem_sel_d   = mem_sel_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_sel_d   = out_sel_q;
`ifdef LU_ISSUE_ZERO_FLAG_EN
    out_zero_d  = out_zero_q;
`endif

    if (push) begin
      mem_a_d[wr_ptr_q]   = in_a;
      mem_b_d[wr_ptr_q]   = in_b;
      mem_sel_d[wr_ptr_q] = in_sel;
      // DEPTH is a power of two, so the pointer wraps naturally.
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      out_res_d   = lu_res;
      out_sel_d   = lu_sel;
      out_valid_d = 1'b1;
`ifdef LU_ISSUE_ZERO_FLAG_EN
      out_zero_d  = (lu_res == '0);
`endif
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
    end else if (out_valid_q && out_ready) begin
      // Consumer took the result and nothing replaces it: data holds.
      out_valid_d = 1'b0;
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a_q[i]   <= '0;
        mem_b_q[i]   <= '0;
        mem_sel_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_sel_q   <= '0;
`ifdef LU_ISSUE_ZERO_FLAG_EN
      out_zero_q  <= 1'b0;
`endif
    end else begin
      mem_a_q     <= mem_a_d;
      mem_b_q     <= mem_b_d;
      mem_sel_q   <= mem_sel_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_sel_q   <= out_sel_d;
`ifdef LU_ISSUE_ZERO_FLAG_EN
      out_zero_q  <= out_zero_d;
`endif
    end
  end

endmodule

// File: tb/tb_lu_issue_stage.sv
// tb_lu_issue_stage
//   Directed bench for lu_issue_stage with a logic_unit stub
//   (res = a ^ b ^ sel). Expected results come from a reference function and
//   hand-computed constants. A scoreboard queue tracks accepted ops and is
//   compared whenever the consumer takes a result.
module tb_lu_issue_stage;

  localparam int W = 64;
  localparam int D = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_sel;
  logic [W-1:0] lu_a;
  logic [W-1:0] lu_b;
  logic [2:0]   lu_sel;
  logic [W-1:0] lu_res;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic [2:0]   out_sel;
  logic [2:0]   count;
`ifdef LU_ISSUE_ZERO_FLAG_EN
  logic         out_zero;
`endif

  int checks;
  int errors;
  int accepted;

  logic [W-1:0] exp_q[$];
  logic [2:0]   exp_sel_q[$];

  // logic_unit stub
  assign lu_res = lu_a ^ lu_b ^ {{(W-3){1'b0}}, lu_sel};

  lu_issue_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sel    (in_sel),
    .lu_a      (lu_a),
    .lu_b      (lu_b),
    .lu_sel    (lu_sel),
    .lu_res    (lu_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_sel   (out_sel),
    .count     (count)
`ifdef LU_ISSUE_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] sel);
    return a ^ b ^ {{(W-3){1'b0}}, sel};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score any output transfer and record any input transfer that
  // happens at the coming edge, then sample 1 time unit after the edge.
  task automatic tick();
    logic [W-1:0] e;
    logic [2:0]   es;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", 64'(out_valid), 64'd0);
      end else begin
        e  = exp_q.pop_front();
        es = exp_sel_q.pop_front();
        check("sb_res", out_res, e);
        check("sb_sel", 64'(out_sel), 64'(es));
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_res(in_a, in_b, in_sel));
      exp_sel_q.push_back(in_sel);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel);
    in_a     = a;
    in_b     = b;
    in_sel   = sel;
    in_valid = 1'b1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 12 && out_valid; c++) tick();
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sel    = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_res", out_res, 64'd0);
    check("rst_out_sel", 64'(out_sel), 64'd0);
    check("rst_lu_a", lu_a, 64'd0);
    check("rst_lu_sel", 64'(lu_sel), 64'd0);
`ifdef LU_ISSUE_ZERO_FLAG_EN
    check("rst_out_zero", 64'(out_zero), 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Single op: 5 ^ 3 ^ 2 = 4, visible after the second edge
    out_ready = 1'b1;
    drive_op(64'd5, 64'd3, 3'd2);
    tick();
    in_valid = 1'b0;
    check("single_count_after_push", 64'(count), 64'd1);
    check("single_lu_a", lu_a, 64'd5);
    check("single_lu_b", lu_b, 64'd3);
    check("single_lu_sel", 64'(lu_sel), 64'd2);
    check("single_not_yet_valid", 64'(out_valid), 64'd0);
    tick();
    check("single_out_valid", 64'(out_valid), 64'd1);
    check("single_out_res", out_res, 64'd4);
    check("single_out_sel", 64'(out_sel), 64'd2);
    check("single_count_after_pop", 64'(count), 64'd0);
    tick();
    check("single_drained", 64'(out_valid), 64'd0);
    check("single_res_holds", out_res, 64'd4);

    // Streaming: 32 ops, one result per cycle after the first
    for (int c = 0; c <= 32; c++) begin
      if (c < 32) begin
        if (c % 2 == 1) drive_op(-64'((c / 8) + 1), 64'((c / 2) % 4), 3'(c % 8));
        else            drive_op(64'(c / 8), 64'((c / 2) % 4), 3'(c % 8));
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c >= 1) check("stream_out_valid", 64'(out_valid), 64'd1);
    end
    tick();
    check("stream_drained", 64'(out_valid), 64'd0);
    check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

    // Back-pressure: slot + DEPTH ops accepted, then in_ready drops
    out_ready = 1'b0;
    accepted  = 0;
    for (int c = 0; c < 7; c++) begin
      drive_op(64'(100 + c), 64'(c), 3'(c % 8));
      if (in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepted", 64'(accepted), 64'd5);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_count_full", 64'(count), 64'd4);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_slot_res", out_res, 64'd100);
    out_ready = 1'b1;
    tick();
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    check("bp_count_after_pop", 64'(count), 64'd3);
    drain();

    // Push+pop at count 2 across the pointer wrap
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_op(64'(200 + c), 64'hFFFF_0000_0000_0000, 3'(c + 1));
      tick();
    end
    check("wrap_count_start", 64'(count), 64'd2);
    check("wrap_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive_op(64'(300 + c), 64'(c * 3), 3'(c % 8));
      tick();
      check("wrap_count_steady", 64'(count), 64'd2);
    end
    drain();

    // Reset mid-stream with count 3
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive_op(64'(400 + c), 64'd1, 3'd7);
      tick();
    end
    in_valid = 1'b0;
    check("midrst_count_before", 64'(count), 64'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_lu_a", lu_a, 64'd0);
    exp_q.delete();
    exp_sel_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("midrst_no_stale", 64'(out_valid), 64'd0);
    end

`ifdef LU_ISSUE_ZERO_FLAG_EN
    // Zero flag: 7^7^0 = 0 sets it, 7^6^0 = 1 clears it, holds under stall
    out_ready = 1'b0;
    drive_op(64'd7, 64'd7, 3'd0);
    tick();
    drive_op(64'd7, 64'd6, 3'd0);
    tick();
    in_valid = 1'b0;
    check("zero_set", 64'(out_zero), 64'd1);
    tick();
    tick();
    check("zero_hold_stall", 64'(out_zero), 64'd1);
    check("zero_hold_res", out_res, 64'd0);
    out_ready = 1'b1;
    tick();
    check("zero_clear", 64'(out_zero), 64'd0);
    check("zero_clear_res", out_res, 64'd1);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
